// File: rtl/envelope_controller_pkg.sv
// Shared definitions for the ADSR envelope controller: state encodings,
// gain-code limits and the gain-to-multiplier helper.
package envelope_controller_pkg;

    // Gain code g: 0 = full level, GAIN_MAX = silent.
    localparam logic [3:0] GAIN_MAX = 4'd8;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_HOLD    = 3'd2,
        ENV_DECAY   = 3'd3,
        ENV_SUSTAIN = 3'd4,
        ENV_RELEASE = 3'd5
    } env_state_t;

    // Multiplier applied to the sample for a gain code: (8 - g), clamped so
    // an out-of-range code can never produce a wrapped, loud multiplier.
    function automatic logic [3:0] gain_mult(input logic [3:0] g);
        return (g >= GAIN_MAX) ? 4'd0 : (GAIN_MAX - g);
    endfunction

endpackage

// File: rtl/envelope_controller_gain_scale.sv
// Combinational gain stage: final_sample = floor(sample * (8 - g) / 8).
module envelope_controller_gain_scale
    import envelope_controller_pkg::*;
(
    input  logic signed [15:0] sample,
    input  logic        [3:0]  gain,
    output logic signed [15:0] final_sample
);

    logic signed [19:0] sample_ext;
    logic signed [19:0] mult_ext;

    // Widen both operands to 20 bits so |sample * 8| cannot overflow.
    always_comb begin
        sample_ext = 20'(sample);
        mult_ext   = 20'(gain_mult(gain));
    end

    // Arithmetic shift floors toward minus infinity (e.g. -1 * 7 / 8 -> -1).
    assign final_sample = 16'((sample_ext * mult_ext) >>> 3);

endmodule

// File: rtl/envelope_controller.sv
// Per-voice ADSR envelope sequencer. An FSM steps the gain code through
// attack/hold/decay/sustain/release on envelope ticks derived from the
// sample strobe, and a combinational gain stage scales the sample.
module envelope_controller
    import envelope_controller_pkg::*;
#(
    parameter int BEAT_DIV   = 4,
    parameter int ATK_SHIFT  = 2,
    parameter int HOLD_STEPS = 2,
    parameter int SUSTAIN_G  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_note,
    input  logic        [5:0]  note_duration,
    input  logic               done_with_note,
    input  logic               generate_next_sample,
    input  logic signed [15:0] sample,
    output logic signed [15:0] final_sample,
    output logic        [3:0]  gain,
    output logic        [2:0]  env_state,
    output logic               env_busy
);

    localparam int DIV_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

    env_state_t       state, state_nxt;
    logic [3:0]       g, g_nxt;
    logic [5:0]       s, s_nxt;
    logic [8:0]       cnt, cnt_nxt;
    logic [DIV_W-1:0] div;
    logic             tick;

    logic [8:0] cnt_inc;
    logic [8:0] atk_raw;
    logic [8:0] atk_len;
    logic [8:0] hold_len;
    logic [8:0] decay_len;

    // Tick divider: one envelope tick per BEAT_DIV sample strobes; a new note
    // restarts the phase so every note's timing is identical.
    // NOTE: clocked state is assigned with <= so every register samples the
    // pre-edge value of its neighbours regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset || new_note) begin
            div <= '0;
        end else if (generate_next_sample) begin
            div <= (div == DIV_W'(BEAT_DIV - 1)) ? '0 : div + 1'b1;
        end
    end

    assign tick = generate_next_sample && (div == DIV_W'(BEAT_DIV - 1));

    // Step lengths in ticks, derived from the latched duration.
    always_comb begin
        cnt_inc   = cnt + 9'd1;
        atk_raw   = 9'(s >> ATK_SHIFT);
        atk_len   = (atk_raw == 9'd0) ? 9'd1 : atk_raw;
        hold_len  = 9'(HOLD_STEPS) * {3'b000, s};
        decay_len = {3'b000, s};
    end

    // State, gain, duration and step-counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ENV_IDLE;
            g     <= GAIN_MAX;
            s     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            s     <= s_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; priority is new_note > done_with_note > tick step.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        s_nxt     = s;
        cnt_nxt   = cnt;

        if (new_note) begin
            s_nxt   = note_duration;
            cnt_nxt = '0;
            if (note_duration == 6'd0) begin
                state_nxt = ENV_IDLE;
                g_nxt     = GAIN_MAX;
            end else begin
                // Keep the current gain so a retrigger does not click.
                state_nxt = ENV_ATTACK;
            end
        end else if (done_with_note && (state == ENV_ATTACK || state == ENV_HOLD ||
                                        state == ENV_DECAY  || state == ENV_SUSTAIN)) begin
            state_nxt = ENV_RELEASE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ENV_ATTACK: begin
                    if (g == 4'd0) begin
                        // Retriggered at full level: nothing to ramp.
                        state_nxt = (HOLD_STEPS == 0) ? ENV_DECAY : ENV_HOLD;
                        cnt_nxt   = '0;
                    end else if (tick) begin
                        if (cnt_inc >= atk_len) begin
                            g_nxt   = g - 4'd1;
                            cnt_nxt = '0;
                            if (g == 4'd1) begin
                                state_nxt = (HOLD_STEPS == 0) ? ENV_DECAY : ENV_HOLD;
                            end
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                ENV_HOLD: begin
                    if (tick) begin
                        if (cnt_inc >= hold_len) begin
                            state_nxt = ENV_DECAY;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                ENV_DECAY: begin
                    if (g >= 4'(SUSTAIN_G)) begin
                        state_nxt = ENV_SUSTAIN;
                        cnt_nxt   = '0;
                    end else if (tick) begin
                        if (cnt_inc >= decay_len) begin
                            g_nxt   = g + 4'd1;
                            cnt_nxt = '0;
                            if (g + 4'd1 == 4'(SUSTAIN_G)) begin
                                state_nxt = ENV_SUSTAIN;
                            end
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                ENV_RELEASE: begin
                    if (g >= GAIN_MAX) begin
                        state_nxt = ENV_IDLE;
                        g_nxt     = GAIN_MAX;
                    end else if (tick) begin
                        g_nxt = g + 4'd1;
                        if (g + 4'd1 == GAIN_MAX) begin
                            state_nxt = ENV_IDLE;
                        end
                    end
                end
                default: begin
                    // IDLE and SUSTAIN hold their gain until an external event.
                end
            endcase
        end
    end

    envelope_controller_gain_scale u_gain_scale (
        .sample       (sample),
        .gain         (g),
        .final_sample (final_sample)
    );

    assign gain      = g;
    assign env_state = state;
    assign env_busy  = (state != ENV_IDLE);

endmodule

// File: tb/tb_envelope_controller.sv
// Directed bench for envelope_controller: ADSR timing, release, gain math,
// retrigger, same-cycle note events, zero duration and mid-note reset.
module tb_envelope_controller;

    logic               clk = 1'b0;
    logic               reset;
    logic               new_note;
    logic        [5:0]  note_duration;
    logic               done_with_note;
    logic               generate_next_sample;
    logic signed [15:0] sample;
    logic signed [15:0] final_sample;
    logic        [3:0]  gain;
    logic        [2:0]  env_state;
    logic               env_busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    localparam int ST_IDLE = 0, ST_ATTACK = 1, ST_HOLD = 2, ST_DECAY = 3,
                   ST_SUSTAIN = 4, ST_RELEASE = 5;

    envelope_controller #(
        .BEAT_DIV   (4),
        .ATK_SHIFT  (2),
        .HOLD_STEPS (2),
        .SUSTAIN_G  (6)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .new_note             (new_note),
        .note_duration        (note_duration),
        .done_with_note       (done_with_note),
        .generate_next_sample (generate_next_sample),
        .sample               (sample),
        .final_sample         (final_sample),
        .gain                 (gain),
        .env_state            (env_state),
        .env_busy             (env_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Strobe the sample clock n times, one pulse every 4 clocks; returns on a
    // negedge with outputs settled.
    task automatic pulse_gen(input int n);
        repeat (n) begin
            @(negedge clk) generate_next_sample = 1'b1;
            @(negedge clk) generate_next_sample = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    // One-cycle note start, optionally with done_with_note in the same cycle.
    task automatic start_note(input logic [5:0] dur, input logic with_done);
        @(negedge clk);
        new_note       = 1'b1;
        note_duration  = dur;
        done_with_note = with_done;
        @(negedge clk);
        new_note       = 1'b0;
        done_with_note = 1'b0;
    endtask

    task automatic end_note();
        @(negedge clk) done_with_note = 1'b1;
        @(negedge clk) done_with_note = 1'b0;
    endtask

    initial begin
        reset                = 1'b0;
        new_note             = 1'b0;
        note_duration        = 6'd0;
        done_with_note       = 1'b0;
        generate_next_sample = 1'b0;
        sample               = 16'sh1234;
        repeat (3) @(negedge clk);

        // 1. Reset state, then full attack/hold/decay to sustain with dur=4.
        check("rst_state", env_state, ST_IDLE);
        check("rst_gain", gain, 8);
        check("rst_busy", env_busy, 0);
        check("rst_out", final_sample, 0);
        reset = 1'b1;

        start_note(6'd4, 1'b0);
        check("atk_enter_state", env_state, ST_ATTACK);
        check("atk_enter_gain", gain, 8);
        check("atk_enter_busy", env_busy, 1);
        pulse_gen(4);
        check("atk_g7", gain, 7);
        pulse_gen(12);
        check("atk_g4", gain, 4);
        pulse_gen(16);
        check("atk_g0", gain, 0);
        check("hold_enter", env_state, ST_HOLD);
        pulse_gen(31);
        check("hold_still", env_state, ST_HOLD);
        pulse_gen(1);
        check("decay_enter", env_state, ST_DECAY);
        check("decay_g0", gain, 0);
        pulse_gen(16);
        check("decay_g1", gain, 1);
        pulse_gen(15);
        check("decay_g1_hold", gain, 1);
        pulse_gen(1);
        check("decay_g2", gain, 2);
        pulse_gen(64);
        check("sus_gain", gain, 6);
        check("sus_state", env_state, ST_SUSTAIN);
        pulse_gen(20);
        check("sus_still", env_state, ST_SUSTAIN);
        check("sus_busy", env_busy, 1);
        sample = 16'sh4000;
        #1 check("sus_out", final_sample, 16'sh1000);

        // 2. Release from sustain.
        end_note();
        check("rel_enter", env_state, ST_RELEASE);
        check("rel_g6", gain, 6);
        pulse_gen(3);
        check("rel_g6_hold", gain, 6);
        pulse_gen(1);
        check("rel_g7", gain, 7);
        pulse_gen(4);
        check("rel_g8", gain, 8);
        check("rel_idle", env_state, ST_IDLE);
        check("rel_busy", env_busy, 0);
        end_note();
        check("done_in_idle", env_state, ST_IDLE);

        // 3. Gain math at g = 8, 4, 2, 1, 0 along a fresh attack.
        start_note(6'd4, 1'b0);
        sample = 16'sh7fff;
        #1 check("mul_g8", final_sample, 0);
        pulse_gen(16);
        sample = -16'sd16384;
        #1 check("mul_g4_neg", final_sample, -8192);
        pulse_gen(8);
        sample = 16'sh4000;
        #1 check("mul_g2", final_sample, 16'sh3000);
        pulse_gen(4);
        sample = -16'sd1;
        #1 check("mul_g1_m1", final_sample, -1);
        sample = 16'sh4000;
        #1 check("mul_g1", final_sample, 16'sh3800);
        pulse_gen(4);
        sample = -16'sd32768;
        #1 check("mul_g0_pass", final_sample, -32768);

        // 4. Retrigger in DECAY at g=3: attack resumes from 3, no jump to 8.
        pulse_gen(32 + 48);
        check("retrig_pre_state", env_state, ST_DECAY);
        check("retrig_pre_gain", gain, 3);
        start_note(6'd4, 1'b0);
        check("retrig_state", env_state, ST_ATTACK);
        check("retrig_gain", gain, 3);
        pulse_gen(4);
        check("retrig_g2", gain, 2);
        pulse_gen(8);
        check("retrig_g0", gain, 0);
        check("retrig_hold", env_state, ST_HOLD);

        // 5. new_note with done_with_note wins; attack at g=0 goes to HOLD.
        start_note(6'd4, 1'b1);
        check("both_attack", env_state, ST_ATTACK);
        @(negedge clk);
        check("both_then_hold", env_state, ST_HOLD);
        start_note(6'd0, 1'b0);
        check("dur0_state", env_state, ST_IDLE);
        check("dur0_gain", gain, 8);
        pulse_gen(8);
        check("dur0_stay", env_state, ST_IDLE);

        // 6. Reset during HOLD, then a full attack with dur=2 (step clamps to 1).
        start_note(6'd4, 1'b0);
        pulse_gen(32);
        check("pre_rst_hold", env_state, ST_HOLD);
        sample = 16'sh1234;
        reset  = 1'b0;
        @(negedge clk);
        check("mid_rst_state", env_state, ST_IDLE);
        check("mid_rst_gain", gain, 8);
        check("mid_rst_out", final_sample, 0);
        reset = 1'b1;
        start_note(6'd2, 1'b0);
        pulse_gen(4);
        check("post_rst_g7", gain, 7);
        pulse_gen(28);
        check("post_rst_g0", gain, 0);
        check("post_rst_hold", env_state, ST_HOLD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
